// File: rtl/display_counter_pkg.sv
// Shared constants for the display counter: segment table, blank
// pattern, per-digit terminal values and small digit helpers.
package display_counter_pkg;

    // Largest value a single digit may hold in each counting mode.
    localparam logic [3:0] MAX_HEX = 4'hF;
    localparam logic [3:0] MAX_BCD = 4'h9;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry i is the glyph for nibble value i.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

    function automatic logic [3:0] digit_max(input logic bcd);
        return bcd ? MAX_BCD : MAX_HEX;
    endfunction

    // A decimal digit can never hold A..F, so loads clamp to 9.
    function automatic logic [3:0] sat_digit(
        input logic [3:0] d,
        input logic       bcd
    );
        return (bcd && (d > MAX_BCD)) ? MAX_BCD : d;
    endfunction

endpackage

// File: rtl/display_counter_digit.sv
// digit_cell: next-value logic for one 4-bit counter digit.
// Ports: cur (present digit), up (direction), cin (carry-in when
// counting up, borrow-in when counting down), bcd (decimal mode),
// nxt (digit value after this step), cout (carry/borrow out).
module digit_cell
    import display_counter_pkg::*;
(
    input  logic [3:0] cur,
    input  logic       up,
    input  logic       cin,
    input  logic       bcd,
    output logic [3:0] nxt,
    output logic       cout
);

    logic [3:0] top;

    assign top = digit_max(bcd);

    // The digit only moves when every lower digit wraps, so cin
    // doubles as "step this digit"; cout says this digit wrapped too.
    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (cur >= top) begin
                    nxt  = 4'h0;
                    cout = 1'b1;
                end else begin
                    nxt = cur + 4'h1;
                end
            end else begin
                if (cur == 4'h0) begin
                    nxt  = top;
                    cout = 1'b1;
                end else if (cur > top) begin
                    // Out-of-range digit: recover to the top value.
                    nxt = top;
                end else begin
                    nxt = cur - 4'h1;
                end
            end
        end
    end

endmodule

// File: rtl/display_counter.sv
// display_counter: loadable up/down hex or BCD counter with a
// terminal-count strobe and per-digit seven-segment decode.
// Ports: Clock, Resetn (async, active low), En, Up, Load,
// D[4*DIGITS-1:0] load value, Q registered count, Tc strobe,
// HEX[7*DIGITS-1:0] active-low gfedcba patterns, digit k at 7k.
// Parameters: DIGITS (1..8), BCD (0 hex, 1 decimal digits).
// Define DISPLAY_COUNTER_BLANK_EN to blank leading-zero digits.
module display_counter
    import display_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BCD    = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Tc,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    q_r;
    logic [W-1:0]    q_nxt;
    logic [W-1:0]    d_sat;
    logic [DIGITS:0] carry;

    // The chain is always stepped; En gates the register instead.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] nib;

        assign nib = q_r[4*g +: 4];

        digit_cell u_cell (
            .cur  (nib),
            .up   (Up),
            .cin  (carry[g]),
            .bcd  (BCD != 0),
            .nxt  (q_nxt[4*g +: 4]),
            .cout (carry[g+1])
        );

        assign d_sat[4*g +: 4] = sat_digit(D[4*g +: 4], BCD != 0);

`ifdef DISPLAY_COUNTER_BLANK_EN
        if (g == 0) begin : g_lsd
            assign HEX[7*g +: 7] = seg_of(nib);
        end else begin : g_msd
            // Blank when this digit and everything above it is 0.
            assign HEX[7*g +: 7] = (q_r[W-1:4*g] == '0)
                                 ? SEG_BLANK : seg_of(nib);
        end
`else
        assign HEX[7*g +: 7] = seg_of(nib);
`endif
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_r <= '0;
        end else if (Load) begin
            q_r <= d_sat;
        end else if (En) begin
            q_r <= q_nxt;
        end
    end

    assign Q = q_r;

    // The top carry-out is set exactly when every digit wraps, i.e.
    // Q is MAX counting up or MIN counting down.
    assign Tc = Resetn & En & ~Load & carry[DIGITS];

endmodule

// File: tb/tb_display_counter.sv
// Scoreboard bench for display_counter: a hex and a BCD instance
// share stimulus and are checked against integer reference models.
module tb_display_counter;

`ifdef DISPLAY_COUNTER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        En     = 1'b0;
    logic        Up     = 1'b0;
    logic        Load   = 1'b0;
    logic [15:0] D      = '0;

    logic [15:0] q_h, q_b;
    logic        tc_h, tc_b;
    logic [27:0] hex_h, hex_b;

    always #5 Clock = ~Clock;

    display_counter #(.DIGITS(4), .BCD(0)) dut_h (
        .Clock (Clock), .Resetn (Resetn), .En (En), .Up (Up),
        .Load (Load), .D (D), .Q (q_h), .Tc (tc_h), .HEX (hex_h)
    );

    display_counter #(.DIGITS(4), .BCD(1)) dut_b (
        .Clock (Clock), .Resetn (Resetn), .En (En), .Up (Up),
        .Load (Load), .D (D), .Q (q_b), .Tc (tc_b), .HEX (hex_b)
    );

    typedef struct {
        logic [15:0] qh;
        logic [15:0] qb;
        logic        th;
        logic        tb;
        logic [27:0] xh;
        logic [27:0] xb;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   val_h       = 0;
    int   val_b       = 0;

    function automatic logic [6:0] pat(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] hex_of(input int val, input int radix);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (BLANK && k > 0 && (val / p) == 0)
                r[7*k +: 7] = 7'b1111111;
            else
                r[7*k +: 7] = pat((val / p) % radix);
            p = p * radix;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_enc(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int bcd_load(input logic [15:0] d);
        int s, p, dig;
        s = 0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            dig = int'(d[4*k +: 4]);
            if (dig > 9) dig = 9;
            s = s + dig * p;
            p = p * 10;
        end
        return s;
    endfunction

    // One clock of stimulus: drive inputs, record what the monitor
    // should see at the following falling edge, then advance models.
    task automatic step(
        input logic        en,
        input logic        up,
        input logic        ld,
        input logic [15:0] d,
        input bit          rst
    );
        exp_t e;
        @(posedge Clock);
        #1;
        En   = en;
        Up   = up;
        Load = ld;
        D    = d;
        if (rst) begin
            Resetn = 1'b0;
            val_h  = 0;
            val_b  = 0;
        end
        e.qh = 16'(val_h);
        e.qb = bcd_enc(val_b);
        e.th = !rst && en && !ld &&
               ((up && val_h == 65535) || (!up && val_h == 0));
        e.tb = !rst && en && !ld &&
               ((up && val_b == 9999) || (!up && val_b == 0));
        e.xh = hex_of(val_h, 16);
        e.xb = hex_of(val_b, 10);
        sb.push_back(e);
        if (ld) begin
            val_h = int'(d);
            val_b = bcd_load(d);
        end else if (en) begin
            val_h = up ? (val_h + 1) % 65536 : (val_h + 65535) % 65536;
            val_b = up ? (val_b + 1) % 10000 : (val_b + 9999) % 10000;
        end
        if (rst) begin
            fork
                begin
                    #6;
                    Resetn = 1'b1;
                end
            join_none
        end
    endtask

    task automatic chk(
        input string       nm,
        input logic [27:0] act,
        input logic [27:0] exp
    );
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s at %0t: got %h want %h",
                         nm, $time, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            chk("q_hex",   28'(q_h),   28'(e.qh));
            chk("tc_hex",  28'(tc_h),  28'(e.th));
            chk("seg_hex", hex_h,      e.xh);
            chk("q_bcd",   28'(q_b),   28'(e.qb));
            chk("tc_bcd",  28'(tc_b),  28'(e.tb));
            chk("seg_bcd", hex_b,      e.xb);
        end
    end

    initial begin
        logic [15:0] d;
        int sel;

        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Full hex cycle: 0000 .. FFFF and back to 0000.
        repeat (65536) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Load wins over enable.
        step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Decimal ripple 0999 -> 1000.
        step(1'b1, 1'b1, 1'b1, 16'h0999, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Down from zero wraps to MAX with Tc beforehand.
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Out-of-range decimal load clamps.
        step(1'b1, 1'b1, 1'b1, 16'h00AF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Mid-cycle reset, then count on the first edge after it.
        step(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Random traffic, with loads steered toward the wrap points.
        repeat (600) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       d = 16'hFFFF;
                1:       d = 16'h9999;
                2:       d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            step($urandom_range(0, 3) != 0,
                 1'($urandom),
                 $urandom_range(0, 15) == 0,
                 d,
                 $urandom_range(0, 199) == 0);
        end

        repeat (3) @(posedge Clock);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
